// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle 8-bit CO224 processor core with internal register file

// 8 x 8-bit register file: two combinational read ports, one synchronous write port.
module reg_file (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [2:0] rd_addr_a_i,
  input  logic [2:0] rd_addr_b_i,
  output logic [7:0] rd_data_a_o,
  output logic [7:0] rd_data_b_o
);

  logic [7:0] registerfile [0:7];

  assign rd_data_a_o = registerfile[rd_addr_a_i];
  assign rd_data_b_o = registerfile[rd_addr_b_i];

  // Clear every register asynchronously on reset; otherwise write the selected register.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < 8; i++) begin
        registerfile[i] <= 8'h00;
      end
    end else if (wr_en_i) begin
      registerfile[wr_addr_i] <= wr_data_i;
    end
  end

endmodule

module cpu (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        INSTRUCTION,
  output logic signed [31:0] PC
);

  typedef enum logic [2:0] {
    ALU_FWD = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_e;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  logic [7:0]  opcode;
  logic [7:0]  offset;
  logic [2:0]  rd_addr;
  logic [2:0]  rt_addr;
  logic [2:0]  rs_addr;
  logic [7:0]  imm;
  logic        unused_rt_hi;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  logic        wr_en;
  logic        is_jump;
  logic        is_beq;
  logic        use_imm;
  alu_op_e     alu_op;

  logic [7:0]  rt_data;
  logic [7:0]  rs_data;
  logic [7:0]  operand_b;
  logic [7:0]  alu_result;
  logic        alu_zero;

  assign opcode       = INSTRUCTION[31:24];
  assign offset       = INSTRUCTION[23:16];
  assign rd_addr      = INSTRUCTION[18:16];
  assign rt_addr      = INSTRUCTION[10:8];
  assign rs_addr      = INSTRUCTION[2:0];
  assign imm          = INSTRUCTION[7:0];
  assign unused_rt_hi = ^INSTRUCTION[15:11];

  assign PC = pc_q;

  // Decode the opcode into register-write, ALU-select and PC-control signals.
  always_comb begin
    wr_en   = 1'b0;
    is_jump = 1'b0;
    is_beq  = 1'b0;
    use_imm = 1'b0;
    alu_op  = ALU_FWD;
    unique case (opcode)
      OP_LOADI: begin wr_en = 1'b1; use_imm = 1'b1; alu_op = ALU_FWD; end
      OP_MOV:   begin wr_en = 1'b1; alu_op = ALU_FWD; end
      OP_ADD:   begin wr_en = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:   begin wr_en = 1'b1; alu_op = ALU_SUB; end
      OP_AND:   begin wr_en = 1'b1; alu_op = ALU_AND; end
      OP_OR:    begin wr_en = 1'b1; alu_op = ALU_OR;  end
      OP_J:     begin is_jump = 1'b1; end
      OP_BEQ:   begin is_beq = 1'b1; alu_op = ALU_SUB; end
      default:  begin end
    endcase
  end

  reg_file reg_file_dut (
    .clk_i       (CLK),
    .resetn_i    (RESET),
    .wr_en_i     (wr_en & RESET),
    .wr_addr_i   (rd_addr),
    .wr_data_i   (alu_result),
    .rd_addr_a_i (rt_addr),
    .rd_addr_b_i (rs_addr),
    .rd_data_a_o (rt_data),
    .rd_data_b_o (rs_data)
  );

  assign operand_b = use_imm ? imm : rs_data;

  // ALU: subtraction adds the two's-complement of operand B; beq reuses it for the zero test.
  always_comb begin
    alu_result = 8'h00;
    unique case (alu_op)
      ALU_FWD: alu_result = operand_b;
      ALU_ADD: alu_result = rt_data + operand_b;
      ALU_SUB: alu_result = rt_data + (~operand_b + 8'd1);
      ALU_AND: alu_result = rt_data & operand_b;
      ALU_OR:  alu_result = rt_data | operand_b;
      default: alu_result = 8'h00;
    endcase
  end

  assign alu_zero = (alu_result == 8'h00);

  // Next PC: sequential fall-through, or word-offset target for j and taken beq.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    branch_target = pc_plus4 + {{22{offset[7]}}, offset, 2'b00};
    pc_d          = pc_plus4;
    if (is_jump || (is_beq && alu_zero)) begin
      pc_d = branch_target;
    end
  end

  // PC register: cleared asynchronously so fetch restarts at address 0.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - self-checking bench for cpu against a behavioural ISA model

module tb_cpu;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic [31:0]        INSTRUCTION;
  logic signed [31:0] PC;

  logic [31:0] imem [0:255];
  logic [7:0]  mreg [0:7];
  logic [31:0] mpc;

  int checks   = 0;
  int failures = 0;

  cpu dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC)
  );

  always #4 CLK = ~CLK;

  assign #2 INSTRUCTION = imem[PC[9:2]];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check($sformatf("%s_pc", tag), PC, mpc);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_r%0d", tag, i), {24'd0, dut.reg_file_dut.registerfile[i]}, {24'd0, mreg[i]});
    end
  endtask

  task automatic model_reset();
    mpc = 32'd0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
  endtask

  // One instruction of the ISA, straight from the opcode table.
  task automatic model_step();
    logic [31:0] ins, tgt;
    logic [7:0]  a, b;
    ins = imem[mpc[9:2]];
    a   = mreg[ins[10:8]];
    b   = mreg[ins[2:0]];
    tgt = mpc + 32'd4 + 32'($signed(ins[23:16]) * 4);
    mpc = mpc + 32'd4;
    case (ins[31:24])
      8'h00: mreg[ins[18:16]] = ins[7:0];
      8'h01: mreg[ins[18:16]] = b;
      8'h02: mreg[ins[18:16]] = a + b;
      8'h03: mreg[ins[18:16]] = a - b;
      8'h04: mreg[ins[18:16]] = a & b;
      8'h05: mreg[ins[18:16]] = a | b;
      8'h06: mpc = tgt;
      8'h07: if (a == b) mpc = tgt;
      default: ;
    endcase
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'hFF000000;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    #2 check_state({tag, "_in_reset"});
    #3 RESET = 1'b1;
    @(negedge CLK);
    check_state({tag, "_released"});
  endtask

  task automatic step_cycle(input string tag);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_state(tag);
  endtask

  initial begin
    clear_imem();
    model_reset();

    // Arithmetic/logic program.
    imem[0] = 32'h00040005;
    imem[1] = 32'h00020009;
    imem[2] = 32'h02060402;
    imem[3] = 32'h03010402;
    imem[4] = 32'h04030402;
    imem[5] = 32'h05050402;
    imem[6] = 32'h01070006;
    do_reset("p1");
    for (int i = 0; i < 3; i++) step_cycle($sformatf("p1_s%0d", i));
    check("p1_pc12", PC, 32'd12);
    check("p1_r6", {24'd0, dut.reg_file_dut.registerfile[6]}, 32'd14);
    for (int i = 3; i < 7; i++) step_cycle($sformatf("p1_s%0d", i));
    check("p1_r1", {24'd0, dut.reg_file_dut.registerfile[1]}, 32'hFC);
    check("p1_r3", {24'd0, dut.reg_file_dut.registerfile[3]}, 32'h01);
    check("p1_r5", {24'd0, dut.reg_file_dut.registerfile[5]}, 32'h0D);
    check("p1_r7", {24'd0, dut.reg_file_dut.registerfile[7]}, 32'd14);
    step_cycle("p1_nop");

    // Reset asserted mid-cycle while add is executing.
    do_reset("mid");
    step_cycle("mid_s0");
    step_cycle("mid_s1");
    check("mid_pc_add", PC, 32'd8);
    #1 RESET = 1'b0;
    #1 check("mid_pc_clr", PC, 32'd0);
    check("mid_r4_clr", {24'd0, dut.reg_file_dut.registerfile[4]}, 32'd0);
    model_reset();
    @(posedge CLK);
    #1 check("mid_r6_nowrite", {24'd0, dut.reg_file_dut.registerfile[6]}, 32'd0);
    check_state("mid_held");
    @(negedge CLK);
    RESET = 1'b1;
    step_cycle("mid_restart");
    check("mid_restart_pc", PC, 32'd4);

    // Jumps forward and backward.
    clear_imem();
    imem[4] = 32'h06020000;
    imem[7] = 32'h06FE0000;
    do_reset("j");
    for (int i = 0; i < 5; i++) step_cycle($sformatf("j_s%0d", i));
    check("j_fwd", PC, 32'd28);
    step_cycle("j_back");
    check("j_bwd", PC, 32'd24);
    for (int i = 0; i < 3; i++) step_cycle($sformatf("j_loop%0d", i));

    // beq taken then not taken.
    clear_imem();
    imem[0] = 32'h00040005;
    imem[1] = 32'h00020009;
    imem[2] = 32'h07010404;
    imem[4] = 32'h07010402;
    do_reset("beq");
    for (int i = 0; i < 3; i++) step_cycle($sformatf("beq_s%0d", i));
    check("beq_taken", PC, 32'd16);
    step_cycle("beq_not");
    check("beq_not_taken", PC, 32'd20);

    // Random programs, including unused opcodes and branches anywhere in memory.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) begin
        int op;
        op = $urandom_range(0, 9);
        imem[i] = {op[7:0], 24'($urandom)};
        if ((op == 7) && ($urandom_range(0, 1) == 1)) imem[i][2:0] = imem[i][10:8];
      end
      do_reset($sformatf("rnd%0d", r));
      for (int i = 0; i < 150; i++) step_cycle($sformatf("rnd%0d_s%0d", r, i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
